// File: rtl/hs_protocol_monitor.sv
// hs_protocol_monitor: per-channel req/ack handshake checker with latency window, drop and spurious-ack detection.
// Define HS_MON_LAT_STATS_EN to build the per-channel worst-legal-latency registers behind max_lat.
module hs_protocol_monitor #(
  parameter int NUM_CH = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 8,
  parameter int CNT_W = 16,
  localparam int LAT_W = $clog2(MAX_LAT + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH-1:0]       ack,
  input  logic [NUM_CH-1:0]       enable,
  input  logic                    err_clr,
  output logic [NUM_CH-1:0]       err_pulse,
  output logic [4*NUM_CH-1:0]     err_sticky,
  output logic [CNT_W-1:0]        err_count,
  output logic [CNT_W-1:0]        txn_count,
  output logic [LAT_W*NUM_CH-1:0] max_lat
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [LAT_W-1:0]   lat_q [NUM_CH];
  logic [LAT_W-1:0]   lat_d [NUM_CH];
  logic [NUM_CH-1:0]  prev_q, qack, rise, legal, any_viol;
  logic [3:0]         viol [NUM_CH];
  logic [4*NUM_CH-1:0] sticky_d;
  logic [5:0]         err_pop, txn_pop;
  logic [CNT_W+5:0]   err_sum, txn_sum;
  logic [CNT_W-1:0]   err_cnt_d, txn_cnt_d;
  assign qack = ack & enable;
  assign rise = req & ~prev_q;
  // viol bits: [3] SPURIOUS, [2] DROP, [1] EARLY, [0] TIMEOUT
  always_comb begin
    sticky_d = err_clr ? '0 : err_sticky;
    err_pop = '0;
    txn_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      lat_d[i] = lat_q[i];
      viol[i] = '0;
      legal[i] = 1'b0;
      case (state_q[i])
        IDLE: if (rise[i]) begin
          if (qack[i]) begin
            state_d[i] = DONE;
            viol[i][1] = (MIN_L != '0);
            legal[i] = (MIN_L == '0);
          end else if (MAX_L == '0) begin
            state_d[i] = DONE;
            viol[i][0] = 1'b1;
          end else begin
            state_d[i] = WAIT;
            lat_d[i] = LAT_W'(1);
          end
        end else viol[i][3] = qack[i] & ~req[i];
        WAIT: if (!req[i]) begin
          state_d[i] = IDLE;
          viol[i][2] = 1'b1;
        end else if (qack[i]) begin
          state_d[i] = DONE;
          viol[i][1] = (lat_q[i] < MIN_L);
          legal[i] = (lat_q[i] >= MIN_L);
        end else if (lat_q[i] == MAX_L) begin
          state_d[i] = DONE;
          viol[i][0] = 1'b1;
        end else lat_d[i] = lat_q[i] + 1'b1;
        DONE: state_d[i] = req[i] ? DONE : IDLE;
        default: state_d[i] = IDLE;
      endcase
      any_viol[i] = |viol[i];
      sticky_d[4*i +: 4] = sticky_d[4*i +: 4] | viol[i];
      err_pop = err_pop + 6'(any_viol[i]);
      txn_pop = txn_pop + 6'(legal[i]);
    end
    err_sum = {6'b0, (err_clr ? {CNT_W{1'b0}} : err_count)} + {{CNT_W{1'b0}}, err_pop};
    txn_sum = {6'b0, (err_clr ? {CNT_W{1'b0}} : txn_count)} + {{CNT_W{1'b0}}, txn_pop};
    err_cnt_d = (|err_sum[CNT_W+5:CNT_W]) ? '1 : err_sum[CNT_W-1:0];
    txn_cnt_d = (|txn_sum[CNT_W+5:CNT_W]) ? '1 : txn_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        lat_q[i] <= '0;
      end
      prev_q <= '1;
      err_pulse <= '0;
      err_sticky <= '0;
      err_count <= '0;
      txn_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i] <= lat_d[i];
      end
      prev_q <= req;
      err_pulse <= any_viol;
      err_sticky <= sticky_d;
      err_count <= err_cnt_d;
      txn_count <= txn_cnt_d;
    end
  end
`ifdef HS_MON_LAT_STATS_EN
  logic [LAT_W*NUM_CH-1:0] max_lat_d;
  logic [LAT_W-1:0]        cur_lat;
  // A completion from IDLE is the same-cycle latency-0 case.
  always_comb begin
    max_lat_d = err_clr ? '0 : max_lat;
    cur_lat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_lat = (state_q[i] == IDLE) ? '0 : lat_q[i];
      if (legal[i] && cur_lat > max_lat_d[LAT_W*i +: LAT_W]) max_lat_d[LAT_W*i +: LAT_W] = cur_lat;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) max_lat <= '0;
    else max_lat <= max_lat_d;
  end
`else
  assign max_lat = '0;
`endif
endmodule

// File: tb/tb_hs_protocol_monitor.sv
// tb_hs_protocol_monitor: directed scenarios plus randomized traffic against a cycle-count based handshake model.
module tb_hs_protocol_monitor;
  localparam int MIN = 1;
  localparam int MAX = 8;
`ifdef HS_MON_LAT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0, ack = '0, enable = '0;
  logic err_clr = 1'b0;
  logic [3:0] err_pulse;
  logic [15:0] err_sticky, err_count, txn_count, max_lat;
  logic s_req = 1'b0, s_ack = 1'b0, s_en = 1'b0;
  logic s_pulse;
  logic [3:0] s_sticky, s_max;
  logic [1:0] s_err, s_txn;
  int checks = 0;
  int errors = 0;
  // reference model: per-channel transaction start cycle, latency is elapsed cycles
  int cyc;
  bit m_prev [4];
  bit m_busy [4];
  bit m_hold [4];
  int m_start [4];
  int m_max [4];
  logic [3:0] exp_pulse;
  logic [15:0] exp_sticky;
  int exp_err, exp_txn;

  always #5 clk = ~clk;

  hs_protocol_monitor u_dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .enable(enable), .err_clr(err_clr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
    .txn_count(txn_count), .max_lat(max_lat)
  );

  hs_protocol_monitor #(.NUM_CH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .req(s_req), .ack(s_ack), .enable(s_en), .err_clr(1'b0),
    .err_pulse(s_pulse), .err_sticky(s_sticky), .err_count(s_err),
    .txn_count(s_txn), .max_lat(s_max)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 1'b1;
      m_busy[i] = 1'b0;
      m_hold[i] = 1'b0;
      m_start[i] = 0;
      m_max[i] = 0;
    end
    exp_pulse = '0;
    exp_sticky = '0;
    exp_err = 0;
    exp_txn = 0;
  endtask

  task automatic model(input logic [3:0] r, input logic [3:0] a, input logic [3:0] e, input logic c);
    logic [3:0] p;
    logic [15:0] st;
    int nv, nl;
    p = '0;
    nv = 0;
    nl = 0;
    st = c ? 16'h0 : exp_sticky;
    if (c) for (int i = 0; i < 4; i++) m_max[i] = 0;
    for (int i = 0; i < 4; i++) begin
      bit q, rs;
      int v, lat;
      q = a[i] && e[i];
      rs = r[i] && !m_prev[i];
      v = -1;
      if (!m_busy[i] && !m_hold[i]) begin
        if (!r[i] && q) v = 3;
        else if (rs) begin
          m_busy[i] = 1'b1;
          m_start[i] = cyc;
        end
      end
      if (m_busy[i]) begin
        lat = cyc - m_start[i];
        if (!r[i]) begin
          v = 2;
          m_busy[i] = 1'b0;
        end else if (q) begin
          m_busy[i] = 1'b0;
          m_hold[i] = 1'b1;
          if (lat < MIN) v = 1;
          else begin
            nl++;
            if (lat > m_max[i]) m_max[i] = lat;
          end
        end else if (lat == MAX) begin
          v = 0;
          m_busy[i] = 1'b0;
          m_hold[i] = 1'b1;
        end
      end else if (m_hold[i] && !r[i]) m_hold[i] = 1'b0;
      if (v >= 0) begin
        p[i] = 1'b1;
        st[4*i+v] = 1'b1;
        nv++;
      end
      m_prev[i] = r[i];
    end
    cyc++;
    exp_pulse = p;
    exp_sticky = st;
    exp_err = (c ? 0 : exp_err) + nv;
    exp_txn = (c ? 0 : exp_txn) + nl;
    if (exp_err > 65535) exp_err = 65535;
    if (exp_txn > 65535) exp_txn = 65535;
  endtask

  function automatic logic [15:0] exp_max();
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[4*i +: 4] = STATS ? 4'(m_max[i]) : 4'h0;
    return m;
  endfunction

  task automatic step(input logic [3:0] r, input logic [3:0] a, input logic [3:0] e, input logic c);
    @(negedge clk);
    req = r;
    ack = a;
    enable = e;
    err_clr = c;
    model(r, a, e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    ack = '0;
    enable = '0;
    err_clr = 1'b0;
    s_req = 1'b0;
    s_ack = 1'b0;
    s_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (err_pulse !== 4'h0) begin errors++; $display("FAIL reset_pulse got %h exp 0", err_pulse); end
    checks++; if (err_sticky !== 16'h0) begin errors++; $display("FAIL reset_sticky got %h exp 0", err_sticky); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
    checks++; if (txn_count !== 16'h0) begin errors++; $display("FAIL reset_txn got %0d exp 0", txn_count); end
    checks++; if (max_lat !== 16'h0) begin errors++; $display("FAIL reset_maxlat got %h exp 0", max_lat); end
  endtask

  task automatic test_legal();
    do_reset();
    step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h1, 4'h1, 1'b0);
    checks++; if (txn_count !== 16'd1) begin errors++; $display("FAIL legal_txn got %0d exp 1", txn_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL legal_err got %0d exp 0", err_count); end
    checks++; if (max_lat[3:0] !== (STATS ? 4'd3 : 4'd0)) begin errors++; $display("FAIL legal_maxlat got %0d exp %0d", max_lat[3:0], STATS ? 3 : 0); end
    step(4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 8; k++) step(4'h2, 4'h0, 4'h0, 1'b0);
    checks++; if (err_pulse !== 4'h0) begin errors++; $display("FAIL timeout_pulse_c8 got %h exp 0", err_pulse); end
    step(4'h2, 4'h0, 4'h0, 1'b0);
    checks++; if (err_pulse !== 4'h2) begin errors++; $display("FAIL timeout_pulse_c9 got %h exp 2", err_pulse); end
    checks++; if (err_sticky !== 16'h0010) begin errors++; $display("FAIL timeout_sticky got %h exp 0010", err_sticky); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL timeout_err got %0d exp 1", err_count); end
    step(4'h2, 4'h0, 4'h0, 1'b0);
    checks++; if (err_pulse !== 4'h0) begin errors++; $display("FAIL timeout_pulse_c10 got %h exp 0", err_pulse); end
    step(4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_early_gating();
    do_reset();
    step(4'h4, 4'h4, 4'h4, 1'b0);
    checks++; if (err_sticky !== 16'h0200) begin errors++; $display("FAIL early_sticky got %h exp 0200", err_sticky); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL early_err got %0d exp 1", err_count); end
    step(4'h0, 4'h0, 4'h0, 1'b0);
    step(4'h4, 4'h0, 4'h0, 1'b0);
    step(4'h4, 4'h0, 4'h0, 1'b0);
    step(4'h4, 4'h4, 4'h0, 1'b0);
    step(4'h4, 4'h4, 4'h0, 1'b0);
    step(4'h4, 4'h4, 4'h4, 1'b0);
    checks++; if (txn_count !== 16'd1) begin errors++; $display("FAIL gating_txn got %0d exp 1", txn_count); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL gating_err got %0d exp 1", err_count); end
    checks++; if (max_lat[11:8] !== (STATS ? 4'd4 : 4'd0)) begin errors++; $display("FAIL gating_maxlat got %0d exp %0d", max_lat[11:8], STATS ? 4 : 0); end
    step(4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_drop_spurious();
    do_reset();
    step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h8, 4'h8, 1'b0);
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL dropspur_err got %0d exp 2", err_count); end
    checks++; if (err_sticky !== 16'h8004) begin errors++; $display("FAIL dropspur_sticky got %h exp 8004", err_sticky); end
    checks++; if (err_pulse !== 4'h9) begin errors++; $display("FAIL dropspur_pulse got %h exp 9", err_pulse); end
    step(4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_clr_collision();
    do_reset();
    step(4'h0, 4'h1, 4'h1, 1'b0);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL clr_pre_err got %0d exp 1", err_count); end
    for (int k = 0; k < 8; k++) step(4'h2, 4'h0, 4'h0, 1'b0);
    step(4'h2, 4'h0, 4'h0, 1'b1);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL clr_err got %0d exp 1", err_count); end
    checks++; if (err_sticky !== 16'h0010) begin errors++; $display("FAIL clr_sticky got %h exp 0010", err_sticky); end
    checks++; if (err_pulse !== 4'h2) begin errors++; $display("FAIL clr_pulse got %h exp 2", err_pulse); end
    step(4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_ack = 1'b1;
      s_en = 1'b1;
      @(posedge clk);
      #1;
      if (k == 1) begin
        checks++; if (s_err !== 2'd2) begin errors++; $display("FAIL sat_mid got %0d exp 2", s_err); end
      end
    end
    checks++; if (s_err !== 2'd3) begin errors++; $display("FAIL sat_err got %0d exp 3", s_err); end
    checks++; if (s_sticky !== 4'h8) begin errors++; $display("FAIL sat_sticky got %h exp 8", s_sticky); end
    @(negedge clk);
    s_ack = 1'b0;
    s_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(4'h0, 4'h8, 4'h8, 1'b0);
    step(4'h1, 4'h0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) step(4'h1, 4'h0, 4'h0, 1'b0);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL rstmid_pre_err got %0d exp 1", err_count); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (err_count !== 16'd0 || err_sticky !== 16'h0) begin errors++; $display("FAIL rstmid_async got %0d/%h exp 0/0", err_count, err_sticky); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) step(4'h1, 4'h0, 4'h0, 1'b0);
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rstmid_noedge got %0d exp 0", err_count); end
    step(4'h0, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h1, 4'h1, 1'b0);
    checks++; if (txn_count !== 16'd1 || err_count !== 16'd0) begin errors++; $display("FAIL rstmid_fresh got txn %0d err %0d exp 1 0", txn_count, err_count); end
    step(4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] r, a, e;
    logic c;
    do_reset();
    r = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
        a[i] = ($urandom_range(0, 9) < 3);
        e[i] = ($urandom_range(0, 9) < 7);
      end
      c = ($urandom_range(0, 49) == 0);
      step(r, a, e, c);
      checks++; if (err_pulse !== exp_pulse) begin errors++; $display("FAIL rnd_pulse cyc %0d got %h exp %h", k, err_pulse, exp_pulse); end
      checks++; if (err_sticky !== exp_sticky) begin errors++; $display("FAIL rnd_sticky cyc %0d got %h exp %h", k, err_sticky, exp_sticky); end
      checks++; if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL rnd_err cyc %0d got %0d exp %0d", k, err_count, exp_err); end
      checks++; if (txn_count !== 16'(exp_txn)) begin errors++; $display("FAIL rnd_txn cyc %0d got %0d exp %0d", k, txn_count, exp_txn); end
      checks++; if (max_lat !== exp_max()) begin errors++; $display("FAIL rnd_maxlat cyc %0d got %h exp %h", k, max_lat, exp_max()); end
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_legal();
    test_timeout();
    test_early_gating();
    test_drop_spurious();
    test_clr_collision();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
